// File: rtl/rcn_testregs_mc.sv
// rcn_testregs_mc: multi-channel test-status slave on the 69-bit rcn ring.
// Each channel has PROGRESS/FAIL/PASS/CTRL registers in a 16-byte slot and a watchdog
// that raises a sticky timeout flag when PROGRESS stops being written.
//
// Ports:
//   clk            ring clock
//   rst_n          asynchronous reset, active low
//   rcn_in         ring input packet
//   rcn_out        ring output packet, registered (1-cycle latency)
//   test_progress  PROGRESS registers, ch0 in [31:0]
//   test_fail      FAIL registers
//   test_pass      PASS registers
//   test_timeout   sticky watchdog-expired flags, one per channel
module rcn_testregs_mc #(
  parameter logic [23:0] ADDR_BASE   = 24'hFFFF00,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned WDOG_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [68:0]              rcn_in,
  output logic [68:0]              rcn_out,
  output logic [NUM_CH*32-1:0]     test_progress,
  output logic [NUM_CH*32-1:0]     test_fail,
  output logic [NUM_CH*32-1:0]     test_pass,
  output logic [NUM_CH-1:0]        test_timeout
);

  localparam int unsigned ChW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [23:0] WinMask = 24'(NUM_CH * 16 - 1);
  localparam logic [31:0] CntLast = 32'(WDOG_CYCLES - 1);

  // Packet decode
  logic [23:0]    byte_addr;
  logic [3:0]     mask;
  logic [31:0]    wdata;
  logic [1:0]     reg_sel;
  logic [ChW-1:0] ch_sel;
  logic           is_wr;
  logic           hit;

  assign byte_addr = {rcn_in[55:34], 2'b00};
  assign mask      = rcn_in[59:56];
  assign wdata     = rcn_in[31:0];
  assign is_wr     = rcn_in[66];
  assign reg_sel   = byte_addr[3:2];
  assign hit       = rcn_in[68] & rcn_in[67] & ((byte_addr & ~WinMask) == ADDR_BASE);

  if (NUM_CH > 1) begin : g_ch_sel
    assign ch_sel = byte_addr[4 +: ChW];
  end else begin : g_ch_sel_one
    assign ch_sel = 1'b0;
  end

  // Register state
  logic [NUM_CH-1:0][31:0] prog_q, prog_d;
  logic [NUM_CH-1:0][31:0] fail_q, fail_d;
  logic [NUM_CH-1:0][31:0] pass_q, pass_d;
  logic [NUM_CH-1:0][31:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]       en_q, en_d;
  logic [NUM_CH-1:0]       to_q, to_d;
  logic [NUM_CH-1:0]       wr_ch;
  logic [68:0]             rcn_out_q, rcn_out_d;
  logic [31:0]             rsp_data;

  function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                        input logic [3:0] be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  always_comb begin
    wr_ch = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      wr_ch[c] = hit & is_wr & (ch_sel == ChW'(c));
    end
  end

  always_comb begin
    prog_d = prog_q;
    fail_d = fail_q;
    pass_d = pass_q;
    cnt_d  = cnt_q;
    en_d   = en_q;
    to_d   = to_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (wr_ch[c]) begin
        case (reg_sel)
          2'd0: prog_d[c] = merge(prog_q[c], wdata, mask);
          2'd1: fail_d[c] = merge(fail_q[c], wdata, mask);
          2'd2: pass_d[c] = merge(pass_q[c], wdata, mask);
          default: begin
            if (mask[0]) begin
              en_d[c] = wdata[0];
              if (wdata[1]) to_d[c] = 1'b0;
            end
          end
        endcase
      end

      // Counter is held at 0 while disabled and on the enabling write; a PROGRESS write
      // takes priority over expiry, and expiry overrides a same-cycle clear.
      if (!en_q[c] || !en_d[c]) begin
        cnt_d[c] = '0;
      end else if (wr_ch[c] && (reg_sel == 2'd0) && (mask != 4'd0)) begin
        cnt_d[c] = '0;
      end else if (cnt_q[c] == CntLast) begin
        cnt_d[c] = '0;
        to_d[c]  = 1'b1;
      end else begin
        cnt_d[c] = cnt_q[c] + 32'd1;
      end
    end
  end

  // Writes respond with the post-write value, reads with the current value.
  always_comb begin
    rsp_data = '0;
    unique case (reg_sel)
      2'd0:    rsp_data = is_wr ? prog_d[ch_sel] : prog_q[ch_sel];
      2'd1:    rsp_data = is_wr ? fail_d[ch_sel] : fail_q[ch_sel];
      2'd2:    rsp_data = is_wr ? pass_d[ch_sel] : pass_q[ch_sel];
      default: rsp_data = is_wr ? {30'd0, to_d[ch_sel], en_d[ch_sel]}
                                : {30'd0, to_q[ch_sel], en_q[ch_sel]};
    endcase
  end

  always_comb begin
    rcn_out_d = rcn_in;
    if (hit) rcn_out_d = {rcn_in[68], 1'b0, rcn_in[66:32], rsp_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcn_out_q <= '0;
      prog_q    <= '0;
      fail_q    <= '0;
      pass_q    <= '0;
      cnt_q     <= '0;
      en_q      <= '0;
      to_q      <= '0;
    end else begin
      rcn_out_q <= rcn_out_d;
      prog_q    <= prog_d;
      fail_q    <= fail_d;
      pass_q    <= pass_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      to_q      <= to_d;
    end
  end

  assign rcn_out       = rcn_out_q;
  assign test_progress = prog_q;
  assign test_fail     = fail_q;
  assign test_pass     = pass_q;
  assign test_timeout  = to_q;

endmodule

// File: tb/tb_rcn_testregs_mc.sv
// Self-checking bench for rcn_testregs_mc: scoreboard of expected ring outputs plus
// direct checks of the status vectors.
module tb_rcn_testregs_mc;

  localparam int unsigned NumCh = 4;
  localparam logic [23:0] Base  = 24'hFFFF00;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [68:0]          rcn_in = '0;
  logic [68:0]          rcn_out;
  logic [NumCh*32-1:0]  test_progress;
  logic [NumCh*32-1:0]  test_fail;
  logic [NumCh*32-1:0]  test_pass;
  logic [NumCh-1:0]     test_timeout;

  rcn_testregs_mc #(
    .ADDR_BASE  (Base),
    .NUM_CH     (NumCh),
    .WDOG_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rcn_in       (rcn_in),
    .rcn_out      (rcn_out),
    .test_progress(test_progress),
    .test_fail    (test_fail),
    .test_pass    (test_pass),
    .test_timeout (test_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [68:0] exp_q[$];

  task automatic check(input string tag, input logic [68:0] got, input logic [68:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [68:0] pkt(input logic req, input logic wr, input logic [5:0] id,
                                      input logic [3:0] be, input logic [23:0] addr,
                                      input logic [1:0] seq, input logic [31:0] data);
    return {1'b1, req, wr, id, be, addr[23:2], seq, data};
  endfunction

  function automatic logic [23:0] raddr(input int ch, input int r);
    return Base + 24'(ch * 16 + r * 4);
  endfunction

  // Drive one packet, queue its expected output, compare one cycle later.
  task automatic step(input string tag, input logic [68:0] pin, input logic [68:0] pexp);
    rcn_in = pin;
    exp_q.push_back(pexp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) check({tag, "_empty"}, 69'd1, 69'd0);
    else check(tag, rcn_out, exp_q.pop_front());
  endtask

  task automatic wr_reg(input string tag, input int ch, input int r, input logic [31:0] d,
                        input logic [3:0] be, input logic [31:0] rsp);
    step(tag, pkt(1'b1, 1'b1, 6'd9, be, raddr(ch, r), 2'd2, d),
         pkt(1'b0, 1'b1, 6'd9, be, raddr(ch, r), 2'd2, rsp));
  endtask

  task automatic rd_reg(input string tag, input int ch, input int r, input logic [31:0] rsp);
    step(tag, pkt(1'b1, 1'b0, 6'd3, 4'hF, raddr(ch, r), 2'd0, 32'd0),
         pkt(1'b0, 1'b0, 6'd3, 4'hF, raddr(ch, r), 2'd0, rsp));
  endtask

  task automatic idle(input string tag);
    step(tag, 69'd0, 69'd0);
  endtask

  logic [68:0] p;

  initial begin
    // Reset state
    #2;
    check("rst_out", rcn_out, 69'd0);
    check("rst_prog", test_progress, '0);
    check("rst_pass", test_pass, '0);
    check("rst_to", 69'(test_timeout), 69'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-stream async reset
    wr_reg("pre_wr", 0, 0, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF);
    check("pre_prog", 69'(test_progress[31:0]), 69'(32'hDEAD_BEEF));
    rd_reg("pre_rd", 0, 0, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    #1;
    check("async_out", rcn_out, 69'd0);
    check("async_prog", test_progress, '0);
    rcn_in = '0;
    #2;
    rst_n = 1'b1;

    // Write/read ch2 PASS
    step("pass_wr", pkt(1'b1, 1'b1, 6'd6, 4'hF, Base + 24'h28, 2'd1, 32'hA5A5_0001),
         pkt(1'b0, 1'b1, 6'd6, 4'hF, Base + 24'h28, 2'd1, 32'hA5A5_0001));
    check("pass_vec", 69'(test_pass[95:64]), 69'(32'hA5A5_0001));
    check("pass_oth", 69'(test_pass[63:0]), 69'd0);
    rd_reg("pass_rd", 2, 2, 32'hA5A5_0001);
    wr_reg("fail_wr", 3, 1, 32'h0BAD_F00D, 4'hF, 32'h0BAD_F00D);
    check("fail_vec", 69'(test_fail[127:96]), 69'(32'h0BAD_F00D));

    // Byte mask
    wr_reg("bm_clr", 1, 0, 32'h0, 4'hF, 32'h0);
    wr_reg("bm_wr", 1, 0, 32'h1122_3344, 4'b0101, 32'h0022_0044);
    check("bm_vec", 69'(test_progress[63:32]), 69'(32'h0022_0044));
    wr_reg("bm_none", 1, 0, 32'hFFFF_FFFF, 4'b0000, 32'h0022_0044);
    check("bm_none_vec", 69'(test_progress[63:32]), 69'(32'h0022_0044));

    // Pass-through
    p = pkt(1'b1, 1'b1, 6'd5, 4'hF, Base - 24'd4, 2'd3, 32'h1234_5678);
    step("pt_below", p, p);
    p = pkt(1'b1, 1'b0, 6'd7, 4'hF, Base + 24'h40 - 24'h100, 2'd1, 32'h0);
    step("pt_far", p, p);
    p = pkt(1'b0, 1'b1, 6'd2, 4'hF, Base + 24'h28, 2'd0, 32'hCAFE_0000);
    step("pt_rsp", p, p);
    p = pkt(1'b1, 1'b1, 6'd1, 4'hF, Base + 24'h28, 2'd0, 32'hCAFE_0001);
    p[68] = 1'b0;
    step("pt_inval", p, p);
    check("pt_pass_kept", 69'(test_pass[95:64]), 69'(32'hA5A5_0001));

    // Watchdog expiry 16 cycles after enable
    wr_reg("wd_en", 0, 3, 32'h1, 4'hF, 32'h1);
    for (int k = 1; k <= 16; k++) begin
      idle("wd_idle");
      check($sformatf("wd_to_%0d", k), 69'(test_timeout), 69'((k == 16) ? 4'b0001 : 4'b0000));
    end
    wr_reg("wd_w1c", 0, 3, 32'h3, 4'hF, 32'h1);
    check("wd_cleared", 69'(test_timeout), 69'd0);
    rd_reg("wd_ctrl_rd", 0, 3, 32'h1);

    // Regular PROGRESS writes keep the watchdog quiet
    for (int n = 0; n < 5; n++) begin
      wr_reg("kick", 0, 0, 32'(n), 4'hF, 32'(n));
      for (int k = 0; k < 9; k++) begin
        idle("kick_idle");
        check("kick_to", 69'(test_timeout), 69'd0);
      end
    end

    // PROGRESS write on the expiry cycle wins
    wr_reg("col_kick0", 0, 0, 32'h100, 4'hF, 32'h100);
    for (int k = 0; k < 15; k++) idle("col_idle0");
    check("col_pre", 69'(test_timeout), 69'd0);
    wr_reg("col_kick1", 0, 0, 32'h101, 4'hF, 32'h101);
    check("col_prog_wins", 69'(test_timeout), 69'd0);

    // W1C on the expiry cycle loses
    for (int k = 0; k < 15; k++) idle("col_idle1");
    check("col_pre2", 69'(test_timeout), 69'd0);
    wr_reg("col_w1c", 0, 3, 32'h3, 4'hF, 32'h3);
    check("col_set_wins", 69'(test_timeout), 69'(4'b0001));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
